// File: rtl/fifo_sched_if.sv
// -----------------------------------------------------------------------------
// fifo_sched_if
//   Bundles the producer, consumer and fifo-side signals of the fifo scheduler.
//   master : the scheduler (drives grant, pop_done and the fifo strobes/data)
//   slave  : the environment (producers, consumer and the fifo flags)
//
//   req        producer push requests, level, one bit per producer
//   req_data   producer data, producer i on bits [8i+7:8i]
//   grant      one-hot 1-cycle pulse, producer's data taken
//   pop_req    consumer pop request, level
//   pop_done   1-cycle pulse, fifo output data valid
//   fifo_in    data to the fifo input
//   fifo_push  fifo push strobe, active-low
//   fifo_pop   fifo pop strobe, active-low
//   fifo_full  fifo full flag
//   fifo_empty fifo empty flag
// -----------------------------------------------------------------------------
interface fifo_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              pop_req;
  logic              pop_done;
  logic [7:0]        fifo_in;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  modport master (
    input  req, req_data, pop_req, fifo_full, fifo_empty,
    output grant, pop_done, fifo_in, fifo_push, fifo_pop
  );

  modport slave (
    output req, req_data, pop_req, fifo_full, fifo_empty,
    input  grant, pop_done, fifo_in, fifo_push, fifo_pop
  );
endinterface

// File: rtl/fifo_sched.sv
// -----------------------------------------------------------------------------
// fifo_sched
//   Serialises round-robin producer pushes and single-consumer pops onto a
//   shared fifo with active-low, edge-detected strobes. Every access is
//   IDLE (decide) -> STROBE (PULSE_CYC low) -> RECOVER (SETTLE_CYC high),
//   so the fifo sees exactly one clean falling edge per access and its flags
//   are only sampled once they have settled.
//
//   Ports
//     clk    clock, rising edge
//     reset  synchronous, active-high
//     bus    fifo_sched_if.master (requests, grants, fifo strobes/data/flags)
//     busy   1 whenever a strobe sequence is in progress
//     level  occupancy counter (tied to 0 unless level tracking is built in)
//
//   Build option
//     FIFO_SCHED_LEVEL_EN : track occupancy in 'level' and also gate pushes on
//                           level<DEPTH and pops on level!=0.
// -----------------------------------------------------------------------------
module fifo_sched #(
  parameter int NREQ       = 2,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 3,
  parameter int DEPTH      = 16,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  fifo_sched_if.master     bus,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam int RR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;
  typedef enum logic       {OP_PUSH, OP_POP}        op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              prefer_pop_q, prefer_pop_d;
  logic [7:0]        fifo_in_q, fifo_in_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              push_n_q, push_n_d;
  logic              pop_n_q, pop_n_d;

  logic [RR_W-1:0]   winner;
  logic              found;
  logic              room, avail;
  logic              push_ok, pop_ok, do_push, do_pop;
  logic              start_push, start_pop;

  // Round-robin search: first asserted request strictly after the last winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(rr_q) + k) % NREQ]) begin
        winner = RR_W'((int'(rr_q) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

`ifdef FIFO_SCHED_LEVEL_EN
  assign room  = (level < LVL_W'(DEPTH));
  assign avail = (level != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (start_push && level != LVL_W'(DEPTH)) begin
      level <= level + 1'b1;
    end else if (start_pop && level != '0) begin
      level <= level - 1'b1;
    end
  end
`else
  assign room  = 1'b1;
  assign avail = 1'b1;
  assign level = '0;
`endif

  // Full and empty together block both ops, which covers the illegal case.
  assign push_ok    = (|bus.req) & ~bus.fifo_full & room;
  assign pop_ok     = bus.pop_req & ~bus.fifo_empty & avail;
  assign do_pop     = pop_ok & (prefer_pop_q | ~push_ok);
  assign do_push    = push_ok & ~do_pop;
  assign start_push = (state_q == IDLE) & do_push;
  assign start_pop  = (state_q == IDLE) & do_pop;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    prefer_pop_d = prefer_pop_q;
    fifo_in_d    = fifo_in_q;
    grant_d      = '0;
    push_n_d     = 1'b1;
    pop_n_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_pop) begin
          state_d      = STROBE;
          op_d         = OP_POP;
          cnt_d        = '0;
          pop_n_d      = 1'b0;
          prefer_pop_d = 1'b0;
        end else if (start_push) begin
          state_d         = STROBE;
          op_d            = OP_PUSH;
          cnt_d           = '0;
          push_n_d        = 1'b0;
          grant_d[winner] = 1'b1;
          fifo_in_d       = bus.req_data[8*int'(winner) +: 8];
          rr_d            = winner;
          prefer_pop_d    = 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          push_n_d = (op_q != OP_PUSH);
          pop_n_d  = (op_q != OP_POP);
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes come straight from flops so the fifo's edge detectors never see
  // decode glitches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_PUSH;
      cnt_q        <= '0;
      rr_q         <= RR_W'(NREQ - 1);
      prefer_pop_q <= 1'b0;
      fifo_in_q    <= '0;
      grant_q      <= '0;
      push_n_q     <= 1'b1;
      pop_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      prefer_pop_q <= prefer_pop_d;
      fifo_in_q    <= fifo_in_d;
      grant_q      <= grant_d;
      push_n_q     <= push_n_d;
      pop_n_q      <= pop_n_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.fifo_in   = fifo_in_q;
  assign bus.fifo_push = push_n_q;
  assign bus.fifo_pop  = pop_n_q;
  assign bus.pop_done  = (state_q == RECOVER) && (op_q == OP_POP) &&
                         (cnt_q == CNT_W'(SETTLE_CYC - 1));
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_sched
//   Self-checking bench for fifo_sched. A transaction-level reference model
//   tracks the position inside the current access and derives every expected
//   output from it; directed scenarios plus a randomized run are compared
//   cycle by cycle, #1 after each rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_sched;
  localparam int NREQ  = 2;
  localparam int P     = 1;
  localparam int S     = 3;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int OW    = 4 + NREQ + 8 + LVL_W;
`ifdef FIFO_SCHED_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             busy;
  logic [LVL_W-1:0] level;

  fifo_sched_if #(.NREQ(NREQ)) bus ();

  fifo_sched #(.NREQ(NREQ), .PULSE_CYC(P), .SETTLE_CYC(S), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: m_pos is the cycle index inside the current access
  // (1..P+S), 0 when idle.
  int         m_pos;
  bit         m_is_push;
  int         m_winner;
  int         m_rr;
  bit         m_prefer_pop;
  logic [7:0] m_fifo_in;
  int         m_level;

  task automatic model_step();
    bit push_ok, pop_ok;
    if (reset) begin
      m_pos = 0; m_is_push = 1'b0; m_winner = 0; m_rr = NREQ - 1;
      m_prefer_pop = 1'b0; m_fifo_in = 8'h00; m_level = 0;
    end else if (m_pos != 0) begin
      m_pos++;
      if (m_pos > P + S) m_pos = 0;
    end else begin
      push_ok = (bus.req != '0) && !bus.fifo_full && (!LEVEL_EN || m_level < DEPTH);
      pop_ok  = bus.pop_req && !bus.fifo_empty && (!LEVEL_EN || m_level > 0);
      if (pop_ok && (m_prefer_pop || !push_ok)) begin
        m_pos = 1; m_is_push = 1'b0; m_prefer_pop = 1'b0;
        if (LEVEL_EN) m_level--;
      end else if (push_ok) begin
        for (int k = NREQ; k >= 1; k--)
          if (bus.req[(m_rr + k) % NREQ]) m_winner = (m_rr + k) % NREQ;
        m_pos = 1; m_is_push = 1'b1; m_rr = m_winner; m_prefer_pop = 1'b1;
        m_fifo_in = bus.req_data[8*m_winner +: 8];
        if (LEVEL_EN) m_level++;
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [NREQ-1:0] g;
    g = '0;
    if (m_is_push && m_pos == 1) g[m_winner] = 1'b1;
    return {!(m_is_push && m_pos >= 1 && m_pos <= P),
            !(!m_is_push && m_pos >= 1 && m_pos <= P),
            g, (!m_is_push && m_pos == P + S), (m_pos != 0),
            m_fifo_in, LVL_W'(m_level)};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {bus.fifo_push, bus.fifo_pop, bus.grant, bus.pop_done, busy,
            bus.fifo_in, level};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic pr,
                       input logic full, input logic empty);
    bus.req = r; bus.pop_req = pr; bus.fifo_full = full; bus.fifo_empty = empty;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    bus.req_data = 16'h1234;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (observed() !== {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, LVL_W'(0)}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", observed(),
               {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, LVL_W'(0)});
    end
    reset = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single_push();
    do_reset();
    bus.req_data = 16'h00A5;
    drive(2'b01, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        bus.req = 2'b00;
        checks++;
        if ({bus.fifo_push, bus.grant, bus.fifo_in, busy} !== {1'b0, 2'b01, 8'hA5, 1'b1}) begin
          errors++;
          $display("FAIL t1_strobe got push=%b grant=%b data=%h busy=%b exp 0 01 a5 1",
                   bus.fifo_push, bus.grant, bus.fifo_in, busy);
        end
      end else begin
        checks++;
        if ({bus.fifo_push, busy} !== {1'b1, (c < 5)}) begin
          errors++;
          $display("FAIL t1_recover_c%0d got push=%b busy=%b exp 1 %b",
                   c, bus.fifo_push, busy, (c < 5));
        end
      end
      checks++;
      if (observed() !== exp_vec()) begin
        errors++;
        $display("FAIL t1_model_c%0d got %h exp %h", c, observed(), exp_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    int gcyc[4];
    logic [NREQ-1:0] gval[4];
    do_reset();
    bus.req_data = 16'($urandom);
    drive(2'b11, 1'b0, 1'b0, 1'b1);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (observed() !== exp_vec()) begin
        errors++;
        $display("FAIL t2_model_c%0d got %h exp %h", c, observed(), exp_vec());
      end
      if (bus.grant != '0 && n < 4) begin
        gcyc[n] = c; gval[n] = bus.grant; n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL t2_grant_count got %0d exp 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gval[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || gcyc[i] != 1 + 5*i) begin
          errors++;
          $display("FAIL t2_grant%0d got %b@%0d exp %b@%0d", i, gval[i], gcyc[i],
                   (i % 2 == 0) ? 2'b01 : 2'b10, 1 + 5*i);
        end
      end
    end
    bus.req = '0;
    repeat (5) tick();
  endtask

  task automatic test_push_pop_alternate();
    string ops;
    int    dones[$];
    do_reset();
    bus.req_data = 16'h003C;
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    ops = "";
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (observed() !== exp_vec()) begin
        errors++;
        $display("FAIL t3_model_c%0d got %h exp %h", c, observed(), exp_vec());
      end
      if (bus.grant != '0) ops = {ops, "U"};
      if (bus.fifo_pop === 1'b0) ops = {ops, "O"};
      if (bus.pop_done === 1'b1) dones.push_back(c);
    end
    checks++;
    if (ops != "UOUO") begin
      errors++;
      $display("FAIL t3_op_order got %s exp UOUO", ops);
    end
    checks++;
    if (dones.size() != 2 || dones[0] != 9 || dones[1] != 19) begin
      errors++;
      $display("FAIL t3_pop_done got %0d pulses exp at cycles 9 and 19", dones.size());
    end
    drive(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flags();
    int grants, dones, busy_cyc;
    do_reset();
    bus.req_data = 16'h0011;
    drive(2'b01, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    drive(2'b01, 1'b1, 1'b1, 1'b0);
    grants = 0; dones = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (observed() !== exp_vec()) begin
        errors++;
        $display("FAIL t4_full_model_c%0d got %h exp %h", c, observed(), exp_vec());
      end
      if (bus.grant != '0) grants++;
      if (bus.pop_done === 1'b1) dones++;
    end
    checks++;
    if (grants != 0 || dones != 2) begin
      errors++;
      $display("FAIL t4_full got grants=%0d pops=%0d exp grants=0 pops=2", grants, dones);
    end
    busy_cyc = 0;
    drive(2'b00, 1'b1, 1'b0, 1'b1);
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || bus.fifo_pop !== 1'b1) busy_cyc++;
    end
    drive(2'b01, 1'b1, 1'b1, 1'b1);
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || bus.fifo_push !== 1'b1 || bus.fifo_pop !== 1'b1) busy_cyc++;
    end
    checks++;
    if (busy_cyc != 0) begin
      errors++;
      $display("FAIL t4_empty_illegal got %0d active cycles exp 0", busy_cyc);
    end
    drive(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_data = 16'h7755;
    drive(2'b10, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL t5_strobe got push=%b exp 0", bus.fifo_push);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.fifo_push, bus.grant, busy} !== {1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL t5_abort got push=%b grant=%b busy=%b exp 1 00 0",
               bus.fifo_push, bus.grant, busy);
    end
    reset = 1'b0;
    bus.req = 2'b11;
    tick();
    checks++;
    if (bus.grant !== 2'b01 || observed() !== exp_vec()) begin
      errors++;
      $display("FAIL t5_rr_restart got grant=%b exp 01", bus.grant);
    end
    bus.req = '0;
    repeat (5) tick();
  endtask

  task automatic test_level();
    int grants;
    do_reset();
    bus.req_data = 16'h0099;
    drive(2'b01, 1'b0, 1'b0, 1'b1);
    grants = 0;
    repeat (25) begin
      tick();
      if (bus.grant != '0) grants++;
    end
    checks++;
    if (grants != (LEVEL_EN ? 4 : 5) || level !== LVL_W'(LEVEL_EN ? 4 : 0)) begin
      errors++;
      $display("FAIL t6_fill got grants=%0d level=%0d exp grants=%0d level=%0d",
               grants, level, LEVEL_EN ? 4 : 5, LEVEL_EN ? 4 : 0);
    end
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    bus.pop_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (level !== LVL_W'(LEVEL_EN ? 3 : 0)) begin
      errors++;
      $display("FAIL t6_pop got level=%0d exp %0d", level, LEVEL_EN ? 3 : 0);
    end
  endtask

  task automatic test_random();
    do_reset();
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && exp_vec()[OW-3-NREQ+1+i] && $urandom_range(1, 0) == 1) begin
          bus.req[i] = 1'b0;
        end else if (bus.req[i] && $urandom_range(99, 0) < 3) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(99, 0) < 40) begin
          bus.req_data[8*i +: 8] = 8'($urandom);
          bus.req[i] = 1'b1;
        end
      end
      bus.pop_req    = ($urandom_range(1, 0) == 1);
      bus.fifo_full  = ($urandom_range(99, 0) < 10);
      bus.fifo_empty = ($urandom_range(99, 0) < 15);
      reset          = ($urandom_range(99, 0) < 2);
      tick();
      checks++;
      if (observed() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_c%0d got %h exp %h", c, observed(), exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.req_data = '0; bus.pop_req = 1'b0;
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b1;
    test_reset();
    test_single_push();
    test_round_robin();
    test_push_pop_alternate();
    test_flags();
    test_reset_mid();
    test_level();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
